// File: rtl/mem_bridge_pkg.sv
// mem_bridge shared defines: word width, defaults, FSM encoding.
package mem_bridge_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int TIMEOUT_DEF    = 15;
  localparam int WBUF_DEPTH_DEF = 2;

  typedef logic [WORD_WIDTH-1:0] wordT;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DONE = 3'd2,
    WR_REQ  = 3'd3,
    WR_DONE = 3'd4
  } stateT;

  function automatic logic isDone(input stateT s);
    return (s == RD_DONE) || (s == WR_DONE);
  endfunction

endpackage

// File: rtl/mem_bridge_wbuf.sv
// mem_bridge posted-write FIFO (address + data per entry).
// Only built when MEM_BRIDGE_WBUF_EN is defined.
module mem_bridge_wbuf
  import mem_bridge_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  wordT pushAddr,
  input  wordT pushData,
  input  logic pop,
  output wordT headAddr,
  output wordT headData,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wordT          addrMem [DEPTH];
  wordT          dataMem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          doPush;
  logic          doPop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push & ~full;
  assign doPop    = pop & ~empty;
  assign headAddr = addrMem[rdPtr];
  assign headData = dataMem[rdPtr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= bump(wrPtr);
      if (doPop)  rdPtr <= bump(rdPtr);
      unique case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      addrMem[wrPtr] <= pushAddr;
      dataMem[wrPtr] <= pushData;
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: CPU data-memory port to req/ack bus with wait timeout.
// Define MEM_BRIDGE_WBUF_EN to post writes through mem_bridge_wbuf.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_read,
  input  logic cpu_write,
  input  wordT cpu_addr,
  input  wordT cpu_wdata,
  output wordT cpu_rdata,
  output logic cpu_stall,
  output logic bus_req,
  output logic bus_we,
  output wordT bus_addr,
  output wordT bus_wdata,
  input  logic bus_ack,
  input  wordT bus_rdata,
  output logic bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  if (TIMEOUT < 1 || WBUF_DEPTH < 1) begin : gBadParam
    $error("mem_bridge: TIMEOUT and WBUF_DEPTH must be >= 1");
  end

  stateT         state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic          reqEnd;
  logic          startWr;
  logic          startRd;
  wordT          wrAddr;
  wordT          wrData;

  assign cntNext = cnt + CW'(1);
  assign reqEnd  = bus_ack | (cntNext == CW'(TIMEOUT));

`ifdef MEM_BRIDGE_WBUF_EN
  logic wbFull;
  logic wbEmpty;
  logic wbPop;

  assign wbPop = (state == WR_REQ) & reqEnd;

  mem_bridge_wbuf #(
    .DEPTH(WBUF_DEPTH)
  ) uWbuf (
    .clk      (clk),
    .rst      (rst),
    .push     (cpu_write),
    .pushAddr (cpu_addr),
    .pushData (cpu_wdata),
    .pop      (wbPop),
    .headAddr (wrAddr),
    .headData (wrData),
    .full     (wbFull),
    .empty    (wbEmpty)
  );

  // Drain posted writes before any read so loads see stored data.
  assign startWr   = ~wbEmpty;
  assign startRd   = cpu_read & ~cpu_write & wbEmpty;
  assign cpu_stall = (cpu_write & wbFull)
                   | (cpu_read & ~cpu_write & (state != RD_DONE));
`else
  assign startWr   = cpu_write;
  assign startRd   = cpu_read & ~cpu_write;
  assign wrAddr    = cpu_addr;
  assign wrData    = cpu_wdata;
  assign cpu_stall = (cpu_read | cpu_write) & ~isDone(state);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (startWr) begin
            state     <= WR_REQ;
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= wrAddr;
            bus_wdata <= wrData;
          end else if (startRd) begin
            state    <= RD_REQ;
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= cpu_addr;
          end
        end
        RD_REQ, WR_REQ: begin
          if (reqEnd) begin
            bus_req <= 1'b0;
            bus_err <= ~bus_ack;
            state   <= (state == RD_REQ) ? RD_DONE : WR_DONE;
            if (state == RD_REQ)
              cpu_rdata <= bus_ack ? bus_rdata : '0;
          end else begin
            cnt <= cntNext;
          end
        end
        RD_DONE, WR_DONE: state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles bus_req may wait for bus_ack before abort.
REQ-002 Parameter WBUF_DEPTH, default 2: posted-write buffer entries (used only with MEM_BRIDGE_WBUF_EN).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cpu_read  in  1  processor data-memory read request, level, held until cpu_stall low.
REQ-006 cpu_write  in  1  processor data-memory write request, level, held until cpu_stall low.
REQ-007 cpu_addr  in  32  word address from the processor MEM stage.
REQ-008 cpu_wdata  in  32  store data.
REQ-009 cpu_rdata  out  32  load data, registered.
REQ-010 cpu_stall  out  1  high while the current request is not complete; pipeline holds.
REQ-011 bus_req  out  1  external memory request.
REQ-012 bus_we  out  1  1 = write, 0 = read.
REQ-013 bus_addr  out  32, bus_wdata  out  32: request address/data.
REQ-014 bus_ack  in  1  external completion strobe, one cycle.
REQ-015 bus_rdata  in  32  read data, valid when bus_ack high.
REQ-016 bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 FSM states IDLE, RD_REQ, RD_DONE, WR_REQ, WR_DONE.
REQ-018 IDLE: cpu_write -> WR_REQ; else cpu_read -> RD_REQ; both high -> write wins, read ignored.
REQ-019 RD_REQ/WR_REQ drive bus_req=1 with bus_we/bus_addr/bus_wdata stable until bus_ack sampled high.
REQ-020 bus_ack in RD_REQ: cpu_rdata <= bus_rdata, -> RD_DONE; in WR_REQ: -> WR_DONE.
REQ-021 RD_DONE/WR_DONE: bus_req=0, cpu_stall=0, next state IDLE; bus_req low at least one cycle between requests.
REQ-022 cpu_stall combinational: (cpu_read|cpu_write) & state not in {RD_DONE, WR_DONE}; minimum 2 stall cycles per access (request cycle N, ack at N+1, release at N+2).
REQ-023 bus_ack outside RD_REQ/WR_REQ is ignored.
REQ-024 Wait counter clears on state entry to *_REQ, increments each cycle without ack; reaching TIMEOUT: bus_req drops, bus_err pulses, read returns cpu_rdata=0, -> corresponding *_DONE.
REQ-025 bus_ack in the same cycle counter reaches TIMEOUT: ack wins, no bus_err.

Reset
REQ-026 rst low: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, cpu_rdata=0, bus_err=0, counter=0, write buffer empty.
REQ-027 rst asserted mid-transaction aborts immediately; outstanding request is dropped, no retry after release.

Configuration
REQ-028 Macro MEM_BRIDGE_WBUF_EN defined: writes are posted into a WBUF_DEPTH FIFO; cpu_stall for a write is low the cycle after acceptance (or same cycle? no: 1 stall cycle max) unless FIFO full.
REQ-029 With MEM_BRIDGE_WBUF_EN: FIFO drains in order through WR_REQ; a read waits in IDLE (stalled) until FIFO empty; FIFO full -> write stalled until one entry drains; simultaneous enqueue and dequeue keeps count unchanged.
REQ-030 Without the macro: no FIFO, writes are blocking per REQ-018..022.

Structure
REQ-031 FSM state encodings, TIMEOUT default and WORD_WIDTH reuse belong in the shared defines file.
REQ-032 Optional FIFO is one sub-module, mem_bridge_wbuf, instantiated only under MEM_BRIDGE_WBUF_EN.

Verification
REQ-033 Read addr 0x40, ack after 3 wait cycles with 0xCAFE0001 -> cpu_rdata=0xCAFE0001, cpu_stall low 1 cycle after ack.
REQ-034 Write 0x1234 to 0x80, ack immediate -> bus_we=1, bus_wdata=0x1234 held until ack; bus_req low next cycle.
REQ-035 Read with no ack -> bus_err pulse at cycle TIMEOUT=15, cpu_rdata=0, FSM back to IDLE.
REQ-036 rst low during RD_REQ -> bus_req=0 asynchronously, all outputs at reset values.
REQ-037 WBUF_EN: three back-to-back writes with ack delayed 4 cycles -> first two accepted without stall, third stalls until first drains; order preserved.
REQ-038 cpu_read and cpu_write both high -> single write on bus, no read issued.
